// File: rtl/router_reg_if.sv
// Byte bus and FSM strobe bundle between the router FSM/source side and the
// router_reg datapath stage; master drives the strobes and data, slave is router_reg.
interface router_reg_if #(
  parameter int WIDTH = 8
);
  logic             pkt_valid;
  logic [WIDTH-1:0] data_in;
  logic             fifo_full;
  logic             detect_add;
  logic             ld_state;
  logic             laf_state;
  logic             full_state;
  logic             lfd_state;
  logic             rst_int_reg;
  logic             parity_done;
  logic             low_pkt_valid;
  logic             err;
  logic             len_err;
  logic [WIDTH-1:0] dout;

  modport master (
    output pkt_valid, data_in, fifo_full, detect_add, ld_state, laf_state,
           full_state, lfd_state, rst_int_reg,
    input  parity_done, low_pkt_valid, err, len_err, dout
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, detect_add, ld_state, laf_state,
           full_state, lfd_state, rst_int_reg,
    output parity_done, low_pkt_valid, err, len_err, dout
  );
endinterface

// File: rtl/router_reg.sv
// Router datapath register stage: header latch, full-FIFO byte parking, running
// XOR parity check. Define ROUTER_REG_LEN_CHK_EN to add the payload length check.
module router_reg #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rstn,
  router_reg_if.slave bus
);

  localparam int LEN_W = 6;

  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] header_byte;
  logic [WIDTH-1:0] full_byte;
  logic [WIDTH-1:0] int_parity;
  logic [WIDTH-1:0] pkt_parity;
  logic             parity_done_q;
  logic             low_pkt_valid_q;
  logic             err_q;
  logic             len_err_q;

  logic header_ok;
  logic payload_accept;
  logic parity_done_set;
  logic parity_mismatch;
  logic len_mismatch;

  // Address 2'b11 has no destination port, so such a header is never latched.
  assign header_ok       = bus.detect_add && bus.pkt_valid && (bus.data_in[1:0] != 2'b11);
  assign payload_accept  = bus.ld_state && bus.pkt_valid && !bus.full_state;
  assign parity_done_set = (bus.ld_state && !bus.fifo_full && !bus.pkt_valid) ||
                           (bus.laf_state && low_pkt_valid_q && !parity_done_q);
  assign parity_mismatch = (int_parity != pkt_parity);

  // NOTE: every sequential process uses non-blocking assignments so all
  // registers sample the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      header_byte <= '0;
    end else if (header_ok) begin
      header_byte <= bus.data_in;
    end
  end

  // A byte arriving while the FIFO is full is parked and replayed in LOAD_AFTER_FULL.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dout_q    <= '0;
      full_byte <= '0;
    end else if (bus.lfd_state) begin
      dout_q <= header_byte;
    end else if (bus.ld_state && !bus.fifo_full) begin
      dout_q <= bus.data_in;
    end else if (bus.ld_state && bus.fifo_full) begin
      full_byte <= bus.data_in;
    end else if (bus.laf_state) begin
      dout_q <= full_byte;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      int_parity <= '0;
    end else if (bus.detect_add) begin
      int_parity <= '0;
    end else if (bus.lfd_state) begin
      int_parity <= int_parity ^ header_byte;
    end else if (payload_accept) begin
      int_parity <= int_parity ^ bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_parity <= '0;
    end else if (bus.ld_state && !bus.pkt_valid) begin
      pkt_parity <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      parity_done_q <= 1'b0;
    end else if (bus.detect_add) begin
      parity_done_q <= 1'b0;
    end else if (parity_done_set) begin
      parity_done_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      low_pkt_valid_q <= 1'b0;
    end else if (bus.rst_int_reg) begin
      low_pkt_valid_q <= 1'b0;
    end else if (bus.ld_state && !bus.pkt_valid) begin
      low_pkt_valid_q <= 1'b1;
    end
  end

`ifdef ROUTER_REG_LEN_CHK_EN
  logic [LEN_W-1:0] payload_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      payload_cnt <= '0;
    end else if (bus.detect_add) begin
      payload_cnt <= '0;
    end else if (payload_accept) begin
      payload_cnt <= payload_cnt + 1'b1;
    end
  end

  // The counter is frozen once the parity byte is seen, so comparing while
  // parity_done is high yields a stable verdict.
  assign len_mismatch = (payload_cnt != header_byte[LEN_W+1:2]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_err_q <= 1'b0;
    end else if (bus.detect_add) begin
      len_err_q <= 1'b0;
    end else if (parity_done_q) begin
      len_err_q <= len_mismatch;
    end
  end
`else
  assign len_mismatch = 1'b0;
  assign len_err_q    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (bus.detect_add) begin
      err_q <= 1'b0;
    end else if (parity_done_q) begin
      err_q <= parity_mismatch || len_mismatch;
    end
  end

  assign bus.dout          = dout_q;
  assign bus.parity_done   = parity_done_q;
  assign bus.low_pkt_valid = low_pkt_valid_q;
  assign bus.err           = err_q;
  assign bus.len_err       = len_err_q;

endmodule
